si_frame_decoder: RTL and testbench

- Sits directly downstream of the FT245 FIFO interface.
- Consumes host bytes from its simple-interface RX port and parses framed register or stream writes.
- Buffers each payload and releases it to the SDR datapath on a valid/ready stream only after the checksum passes.
- Returns a one-byte ACK or NAK to the host through the FT245 simple-interface TX port.

---
 rtl/ft_frame_pkg.sv | 18 +
 rtl/si_frame_buf.sv | 21 ++
 rtl/si_frame_decoder.sv | 173 +++++++++++++++++
 tb/tb_si_frame_decoder.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ft_frame_pkg.sv
// rtl/ft_frame_pkg.sv - decoder state encoding and default protocol byte values
package ft_frame_pkg;

  typedef enum logic [2:0] {
    HUNT,
    ADDR,
    LEN,
    DATA,
    CHK,
    EMIT,
    REPLY
  } frame_state_t;

  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;
  localparam logic [7:0] DEF_ACK_BYTE  = 8'h06;
  localparam logic [7:0] DEF_NAK_BYTE  = 8'h15;

endpackage

// File: rtl/si_frame_buf.sv
// rtl/si_frame_buf.sv - payload buffer, simple dual-port RAM with registered 1-cycle read
module si_frame_buf #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/si_frame_decoder.sv
// rtl/si_frame_decoder.sv - FT245 frame parser with checksum-gated payload stream and ACK/NAK reply
// Optional frame statistics outputs are built when SI_FRAME_STATS_EN is defined.
module si_frame_decoder
  import ft_frame_pkg::*;
#(
  parameter int         MAX_LEN        = 64,
  parameter logic [7:0] SYNC_BYTE      = DEF_SYNC_BYTE,
  parameter logic [7:0] ACK_BYTE       = DEF_ACK_BYTE,
  parameter logic [7:0] NAK_BYTE       = DEF_NAK_BYTE,
  parameter int         TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data_si,
  input  logic        rx_rdy_si,
  output logic        rx_ack_si,
  output logic [7:0]  tx_data_si,
  output logic        tx_rdy_si,
  input  logic        tx_ack_si,
  output logic [7:0]  m_addr,
  output logic [7:0]  m_data,
  output logic        m_valid,
  input  logic        m_ready,
`ifdef SI_FRAME_STATS_EN
  output logic [15:0] stat_good,
  output logic [15:0] stat_bad,
  output logic [15:0] stat_timeout,
`endif
  output logic        m_last
);

  localparam int IW = $clog2(MAX_LEN + 1);
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  frame_state_t  state;
  logic [IW-1:0] len_q;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;
  logic [IW-1:0] rd_next;
  logic [7:0]    csum;
  logic [TW-1:0] to_cnt;
  logic [7:0]    rd_data;
  logic          in_frame;
  logic          take;
  logic          timeout;
  logic          hs;
  logic          len_bad;
  logic          csum_ok;

  assign in_frame = state inside {ADDR, LEN, DATA, CHK};
  assign take     = rx_rdy_si && !rx_ack_si && (in_frame || state == HUNT);
  assign timeout  = in_frame && !take && (to_cnt == TO_LAST);
  assign len_bad  = (rx_data_si == 8'd0) || (rx_data_si > 8'(MAX_LEN));
  assign csum_ok  = (rx_data_si == csum);
  assign hs       = m_valid && m_ready;
  assign m_last   = m_valid && (rd_idx == len_q - IW'(1));
  assign m_data   = m_valid ? rd_data : 8'h00;

  // Read address runs one index ahead on a handshake so the RAM latency is hidden.
  assign rd_next = (hs && !m_last) ? rd_idx + IW'(1) : rd_idx;

  si_frame_buf #(.DEPTH(MAX_LEN), .AW(AW)) u_buf (
    .clk     (clk),
    .wr_en   (state == DATA && take),
    .wr_addr (AW'(wr_idx)),
    .wr_data (rx_data_si),
    .rd_addr (AW'(rd_next)),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= HUNT;
      rx_ack_si  <= 1'b0;
      tx_data_si <= 8'h00;
      tx_rdy_si  <= 1'b0;
      m_addr     <= 8'h00;
      m_valid    <= 1'b0;
      len_q      <= '0;
      wr_idx     <= '0;
      rd_idx     <= '0;
      csum       <= 8'h00;
      to_cnt     <= '0;
    end else begin
      rx_ack_si <= take;
      if (take || !in_frame) to_cnt <= '0;
      else                   to_cnt <= to_cnt + TW'(1);

      if (timeout) begin
        state      <= REPLY;
        tx_data_si <= NAK_BYTE;
        tx_rdy_si  <= 1'b1;
        to_cnt     <= '0;
      end else begin
        case (state)
          HUNT: if (take && rx_data_si == SYNC_BYTE) state <= ADDR;
          ADDR: if (take) begin
            m_addr <= rx_data_si;
            csum   <= rx_data_si;
            state  <= LEN;
          end
          LEN: if (take) begin
            if (len_bad) begin
              state      <= REPLY;
              tx_data_si <= NAK_BYTE;
              tx_rdy_si  <= 1'b1;
            end else begin
              len_q  <= IW'(rx_data_si);
              csum   <= csum ^ rx_data_si;
              wr_idx <= '0;
              rd_idx <= '0;
              state  <= DATA;
            end
          end
          DATA: if (take) begin
            csum   <= csum ^ rx_data_si;
            wr_idx <= wr_idx + IW'(1);
            if (wr_idx == len_q - IW'(1)) state <= CHK;
          end
          CHK: if (take) begin
            if (csum_ok) begin
              state   <= EMIT;
              m_valid <= 1'b1;
            end else begin
              state      <= REPLY;
              tx_data_si <= NAK_BYTE;
              tx_rdy_si  <= 1'b1;
            end
          end
          EMIT: if (hs) begin
            if (m_last) begin
              m_valid    <= 1'b0;
              rd_idx     <= '0;
              state      <= REPLY;
              tx_data_si <= ACK_BYTE;
              tx_rdy_si  <= 1'b1;
            end else begin
              rd_idx <= rd_idx + IW'(1);
            end
          end
          REPLY: if (tx_ack_si) begin
            tx_rdy_si <= 1'b0;
            state     <= HUNT;
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

`ifdef SI_FRAME_STATS_EN
  logic good_ev;
  logic bad_ev;

  assign good_ev = (state == EMIT) && hs && m_last;
  assign bad_ev  = take && (((state == LEN) && len_bad) || ((state == CHK) && !csum_ok));

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_good    <= 16'h0000;
      stat_bad     <= 16'h0000;
      stat_timeout <= 16'h0000;
    end else begin
      if (good_ev && stat_good != 16'hFFFF)    stat_good    <= stat_good + 16'd1;
      if (bad_ev && stat_bad != 16'hFFFF)      stat_bad     <= stat_bad + 16'd1;
      if (timeout && stat_timeout != 16'hFFFF) stat_timeout <= stat_timeout + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_si_frame_decoder.sv
// tb/tb_si_frame_decoder.sv - randomized frame stimulus against a frame-level reference model
module tb_si_frame_decoder;

  localparam int MAX_LEN = 64;
  localparam int TIMEOUT = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data_si = 8'h00;
  logic        rx_rdy_si = 1'b0;
  logic        rx_ack_si;
  logic [7:0]  tx_data_si;
  logic        tx_rdy_si;
  logic        tx_ack_si = 1'b0;
  logic [7:0]  m_addr;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic        m_last;
`ifdef SI_FRAME_STATS_EN
  logic [15:0] stat_good;
  logic [15:0] stat_bad;
  logic [15:0] stat_timeout;
`endif

  si_frame_decoder #(.MAX_LEN(MAX_LEN), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_data_si   (rx_data_si),
    .rx_rdy_si    (rx_rdy_si),
    .rx_ack_si    (rx_ack_si),
    .tx_data_si   (tx_data_si),
    .tx_rdy_si    (tx_rdy_si),
    .tx_ack_si    (tx_ack_si),
    .m_addr       (m_addr),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
`ifdef SI_FRAME_STATS_EN
    .stat_good    (stat_good),
    .stat_bad     (stat_bad),
    .stat_timeout (stat_timeout),
`endif
    .m_last       (m_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    logic       last;
    int         cyc;
  } beat_t;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         ready_mode = 1;
  int         exp_good = 0;
  int         exp_bad = 0;
  int         exp_to = 0;
  beat_t      got_q[$];
  logic [7:0] reply_q[$];
  logic       held = 1'b0;
  logic [7:0] held_data;
  logic       held_last;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream sink: records handshakes and requires stalled beats to stay put.
  always @(negedge clk) begin
    if (rst) begin
      held = 1'b0;
    end else begin
      if (held) begin
        check_eq("stall valid", m_valid, 1);
        check_eq("stall data", m_data, held_data);
        check_eq("stall last", m_last, held_last);
      end
      held      = m_valid && !m_ready;
      held_data = m_data;
      held_last = m_last;
      if (m_valid && m_ready) got_q.push_back('{m_addr, m_data, m_last, cyc});
    end
  end

  always begin
    @(posedge clk);
    #1;
    m_ready = (ready_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
  end

  // FT245 TX side: latch a pending reply and pulse the ack for one cycle.
  always begin
    @(posedge clk);
    #1;
    if (tx_ack_si) tx_ack_si = 1'b0;
    else if (tx_rdy_si && !rst) begin
      reply_q.push_back(tx_data_si);
      tx_ack_si = 1'b1;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bit acked = 0;
    rx_data_si = b;
    rx_rdy_si  = 1'b1;
    for (int n = 0; n < 2000 && !acked; n++) begin
      @(posedge clk);
      #1;
      acked = rx_ack_si;
    end
    rx_rdy_si = 1'b0;
    check_eq("rx ack", acked, 1);
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, " m_valid"}, m_valid, 0);
    check_eq({tag, " m_last"}, m_last, 0);
    check_eq({tag, " m_data"}, m_data, 0);
    check_eq({tag, " m_addr"}, m_addr, 0);
    check_eq({tag, " tx_rdy"}, tx_rdy_si, 0);
    check_eq({tag, " tx_data"}, tx_data_si, 0);
    check_eq({tag, " rx_ack"}, rx_ack_si, 0);
  endtask

  // chk_mode: 0 correct checksum, 1 checksum forced to 00, 2 checksum flipped by a random mask
  task automatic run_frame(input logic [7:0] addr, input int len, input logic [7:0] data[$],
                           input int chk_mode, input int rmode, input string tag);
    logic [7:0] real_chk;
    logic [7:0] sent_chk;
    logic [7:0] bytes[$];
    bit         len_ok;
    bit         good;
    ready_mode = rmode;
    got_q.delete();
    reply_q.delete();
    real_chk = addr ^ len[7:0];
    foreach (data[i]) real_chk ^= data[i];
    if (chk_mode == 1)      sent_chk = 8'h00;
    else if (chk_mode == 2) sent_chk = real_chk ^ 8'($urandom_range(1, 255));
    else                    sent_chk = real_chk;
    len_ok = (len >= 1) && (len <= MAX_LEN);
    good   = len_ok && (sent_chk == real_chk);
    bytes  = {8'hA5, addr, len[7:0]};
    if (len_ok) begin
      foreach (data[i]) bytes.push_back(data[i]);
      bytes.push_back(sent_chk);
    end
    foreach (bytes[i]) begin
      send_byte(bytes[i]);
      idle($urandom_range(0, 3));
    end
    for (int n = 0; n < 3000 && reply_q.size() == 0; n++) idle(1);
    check_eq({tag, " reply count"}, reply_q.size(), 1);
    if (reply_q.size() > 0) check_eq({tag, " reply"}, reply_q[0], good ? 8'h06 : 8'h15);
    check_eq({tag, " beats"}, got_q.size(), good ? len : 0);
    for (int i = 0; i < got_q.size() && i < len; i++) begin
      check_eq({tag, " addr"}, got_q[i].addr, addr);
      check_eq({tag, " data"}, got_q[i].data, data[i]);
      check_eq({tag, " last"}, got_q[i].last, (i == len - 1));
      if (rmode == 1 && i > 0) check_eq({tag, " gap"}, got_q[i].cyc - got_q[i-1].cyc, 1);
    end
    if (good) exp_good++;
    else      exp_bad++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q[$];
    logic [7:0] chk;
    int         n;
    int         len;

    idle(3);
    check_idle("reset");
`ifdef SI_FRAME_STATS_EN
    check_eq("reset stat_good", stat_good, 0);
    check_eq("reset stat_timeout", stat_timeout, 0);
`endif
    rst = 1'b0;
    idle(2);

    q = {8'h11, 8'h22, 8'h33};
    run_frame(8'h10, 3, q, 0, 1, "basic");
    run_frame(8'h10, 3, q, 1, 1, "bad chk");
    run_frame(8'h10, 3, q, 0, 1, "after bad");

    send_byte(8'h00);
    send_byte(8'hFF);
    run_frame(8'h10, 3, q, 0, 1, "garbage");

    q.delete();
    run_frame(8'h22, 0, q, 0, 1, "len0");
    run_frame(8'h22, MAX_LEN + 1, q, 0, 1, "len over");
    for (int i = 0; i < MAX_LEN; i++) q.push_back(8'($urandom));
    run_frame(8'h5C, MAX_LEN, q, 0, 1, "len max");

    got_q.delete();
    reply_q.delete();
    send_byte(8'hA5);
    send_byte(8'h10);
    n = 0;
    while (!tx_rdy_si && n < 3 * TIMEOUT) begin
      idle(1);
      n++;
    end
    check_eq("timeout window", (n >= TIMEOUT - 2) && (n <= TIMEOUT + 2), 1);
    for (int k = 0; k < 10 && reply_q.size() == 0; k++) idle(1);
    check_eq("timeout reply count", reply_q.size(), 1);
    if (reply_q.size() > 0) check_eq("timeout reply", reply_q[0], 8'h15);
    check_eq("timeout beats", got_q.size(), 0);
    exp_to++;
`ifdef SI_FRAME_STATS_EN
    idle(2);
    check_eq("stat_timeout", stat_timeout, exp_to);
`endif

    for (int f = 0; f < 12; f++) begin
      len = $urandom_range(1, MAX_LEN);
      q.delete();
      for (int i = 0; i < len; i++) q.push_back(8'($urandom));
      run_frame(8'($urandom), len, q, ($urandom_range(0, 3) == 0) ? 2 : 0,
                $urandom_range(0, 1), "random");
    end

    q.delete();
    for (int i = 0; i < 20; i++) q.push_back(8'($urandom));
    chk = 8'h33 ^ 8'd20;
    foreach (q[i]) chk ^= q[i];
    ready_mode = 0;
    got_q.delete();
    reply_q.delete();
    send_byte(8'hA5);
    send_byte(8'h33);
    send_byte(8'd20);
    foreach (q[i]) send_byte(q[i]);
    send_byte(chk);
    for (int k = 0; k < 2000 && got_q.size() < 5; k++) idle(1);
    check_eq("mid emit reached", got_q.size() >= 5, 1);
    rst = 1'b1;
    idle(2);
    check_idle("mid emit reset");
    rst = 1'b0;
    exp_good = 0;
    exp_bad  = 0;
    exp_to   = 0;
    idle(50);
    check_eq("no reply after reset", reply_q.size(), 0);
    check_eq("tx_rdy after reset", tx_rdy_si, 0);
    check_eq("m_valid after reset", m_valid, 0);

    q = {8'hA5, 8'h01, 8'h7E};
    run_frame(8'h44, 3, q, 0, 1, "post reset");
`ifdef SI_FRAME_STATS_EN
    idle(2);
    check_eq("stat_good", stat_good, exp_good);
    check_eq("stat_bad", stat_bad, exp_bad);
    check_eq("stat_timeout final", stat_timeout, exp_to);
`endif

    idle(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
